// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and default widths for the decode stage
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int CTRL_W_DEF = 8;

  // Branch kind from the control unit; 11 is reserved and never branches
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } branch_e;

  // Branch operand source; 11 falls back to the register file
  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_ALUM = 2'b01,
    FWD_RESW = 2'b10,
    FWD_RF2  = 2'b11
  } fwd_e;

  // Address width for a register file of n entries (at least 1 bit)
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// rtl/decode_stage_p_if.sv - decode stage signal bundle with driver/stage modports
interface decode_stage_p_if
  import mips_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int CTRL_W = CTRL_W_DEF
);
  localparam int AW = addr_w(NREG);

  // Decode-side inputs
  logic [INSTR_W-1:0] instructionD;
  logic [XLEN-1:0]    pcplus4D;
  logic               validD;
  logic [CTRL_W-1:0]  ctrlD;
  logic [1:0]         BranchD;
  logic               StallE;
  logic               FlushE;
  logic               RegWriteW;
  logic [AW-1:0]      WriteRegW;
  logic [XLEN-1:0]    resultW;
  logic [XLEN-1:0]    ALUresultM;
  logic [1:0]         ForwardAD;
  logic [1:0]         ForwardBD;

  // Branch resolution and hazard-unit fields
  logic               PCsrcD;
  logic [XLEN-1:0]    pcBranchD;
  logic [AW-1:0]      rsD;
  logic [AW-1:0]      rtD;

  // ID/EX register contents
  logic               validE;
  logic [CTRL_W-1:0]  ctrlE;
  logic [XLEN-1:0]    SrcAE;
  logic [XLEN-1:0]    SrcBE;
  logic [XLEN-1:0]    signImmE;
  logic [4:0]         rsE;
  logic [4:0]         rtE;
  logic [4:0]         rdE;
  logic [4:0]         shamtE;

  modport master (
    output instructionD, pcplus4D, validD, ctrlD, BranchD, StallE, FlushE,
           RegWriteW, WriteRegW, resultW, ALUresultM, ForwardAD, ForwardBD,
    input  PCsrcD, pcBranchD, rsD, rtD, validE, ctrlE, SrcAE, SrcBE,
           signImmE, rsE, rtE, rdE, shamtE
  );

  modport slave (
    input  instructionD, pcplus4D, validD, ctrlD, BranchD, StallE, FlushE,
           RegWriteW, WriteRegW, resultW, ALUresultM, ForwardAD, ForwardBD,
    output PCsrcD, pcBranchD, rsD, rtD, validE, ctrlE, SrcAE, SrcBE,
           signImmE, rsE, rtE, rdE, shamtE
  );

endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two combinational read ports, one write port, r0 hardwired to zero
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREG      = NREG_DEF,
  parameter bit WB_BYPASS = 1'b1,
  localparam int AW       = addr_w(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  // Storage: cleared on reset, r0 never written so it stays zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (int'(waddr_i) < NREG)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: zero for r0, optional same-cycle write-back forwarding
  always_comb begin
    rdata1_o = '0;
    if (raddr1_i != '0 && int'(raddr1_i) < NREG) begin
      if (WB_BYPASS && wr_en && (waddr_i == raddr1_i)) begin
        rdata1_o = wdata_i;
      end else begin
        rdata1_o = regs_q[raddr1_i];
      end
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rdata2_o = '0;
    if (raddr2_i != '0 && int'(raddr2_i) < NREG) begin
      if (WB_BYPASS && wr_en && (waddr_i == raddr2_i)) begin
        rdata2_o = wdata_i;
      end else begin
        rdata2_o = regs_q[raddr2_i];
      end
    end
  end

endmodule

// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - MIPS-style decode stage: regfile read, branch resolve, ID/EX register
module decode_stage_p
  import mips_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREG      = NREG_DEF,
  parameter int CTRL_W    = CTRL_W_DEF,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            CLK,
  input  logic            reset_n,
  decode_stage_p_if.slave bus
);

  localparam int AW = addr_w(NREG);

  logic [INSTR_W-1:0] instr;
  logic [4:0]         rs_f, rt_f, rd_f, shamt_f;
  logic [XLEN-1:0]    sign_imm;
  logic [XLEN-1:0]    rd1, rd2;
  logic [XLEN-1:0]    br_a, br_b;
  logic               br_eq;
  logic               unused_instr_bits;

  assign instr   = bus.instructionD;
  assign rs_f    = instr[25:21];
  assign rt_f    = instr[20:16];
  assign rd_f    = instr[15:11];
  assign shamt_f = instr[10:6];

  // Opcode and funct belong to the control unit, not this stage
  assign unused_instr_bits = ^{instr[31:26], instr[5:0]};

  assign bus.rsD = AW'(rs_f);
  assign bus.rtD = AW'(rt_f);

  assign sign_imm = XLEN'($signed(instr[15:0]));

  regfile_2r1w #(
    .XLEN      (XLEN),
    .NREG      (NREG),
    .WB_BYPASS (WB_BYPASS)
  ) u_regfile (
    .clk_i    (CLK),
    .rst_ni   (reset_n),
    .we_i     (bus.RegWriteW),
    .waddr_i  (bus.WriteRegW),
    .wdata_i  (bus.resultW),
    .raddr1_i (bus.rsD),
    .rdata1_o (rd1),
    .raddr2_i (bus.rtD),
    .rdata2_o (rd2)
  );

  // Branch target: word offset relative to PC+4, wraps modulo 2^XLEN
  assign bus.pcBranchD = bus.pcplus4D + (sign_imm << 2);

  // Branch operand A: pick the freshest copy the hazard unit points at
  always_comb begin
    br_a = rd1;
    case (fwd_e'(bus.ForwardAD))
      FWD_ALUM: br_a = bus.ALUresultM;
      FWD_RESW: br_a = bus.resultW;
      default:  br_a = rd1;
    endcase
  end

  // Branch operand B: same selection as operand A
  always_comb begin
    br_b = rd2;
    case (fwd_e'(bus.ForwardBD))
      FWD_ALUM: br_b = bus.ALUresultM;
      FWD_RESW: br_b = bus.resultW;
      default:  br_b = rd2;
    endcase
  end

  assign br_eq = (br_a == br_b);

  // Resolve in decode so a taken branch costs no extra cycle; bubbles never branch
  always_comb begin
    bus.PCsrcD = 1'b0;
    if (bus.validD) begin
      case (branch_e'(bus.BranchD))
        BR_BEQ:  bus.PCsrcD = br_eq;
        BR_BNE:  bus.PCsrcD = !br_eq;
        default: bus.PCsrcD = 1'b0;
      endcase
    end
  end

  // ID/EX pipeline register
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   srca_q, srca_d;
  logic [XLEN-1:0]   srcb_q, srcb_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        shamt_q, shamt_d;

  // Next ID/EX contents: flush beats stall beats load; flushed fields are all zero
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    shamt_d = shamt_q;
    if (bus.FlushE) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      srca_d  = '0;
      srcb_d  = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      shamt_d = '0;
    end else if (!bus.StallE) begin
      valid_d = bus.validD;
      ctrl_d  = bus.validD ? bus.ctrlD : '0;
      srca_d  = rd1;
      srcb_d  = rd2;
      imm_d   = sign_imm;
      rs_d    = rs_f;
      rt_d    = rt_f;
      rd_d    = rd_f;
      shamt_d = shamt_f;
    end
  end

  // ID/EX state: asynchronous clear wins over any pending stall or flush
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      shamt_q <= shamt_d;
    end
  end

  assign bus.validE   = valid_q;
  assign bus.ctrlE    = ctrl_q;
  assign bus.SrcAE    = srca_q;
  assign bus.SrcBE    = srcb_q;
  assign bus.signImmE = imm_q;
  assign bus.rsE      = rs_q;
  assign bus.rtE      = rt_q;
  assign bus.rdE      = rd_q;
  assign bus.shamtE   = shamt_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// tb/tb_decode_stage_p.sv - directed self-checking bench for decode_stage_p
module tb_decode_stage_p;

  logic CLK;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  decode_stage_p_if #(.XLEN(32), .NREG(32), .CTRL_W(8)) bus ();

  decode_stage_p #(
    .XLEN      (32),
    .NREG      (32),
    .CTRL_W    (8),
    .WB_BYPASS (1'b1)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {6'h04, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.instructionD = '0;
    bus.pcplus4D     = '0;
    bus.validD       = 1'b0;
    bus.ctrlD        = '0;
    bus.BranchD      = 2'b00;
    bus.StallE       = 1'b0;
    bus.FlushE       = 1'b0;
    bus.RegWriteW    = 1'b0;
    bus.WriteRegW    = '0;
    bus.resultW      = '0;
    bus.ALUresultM   = '0;
    bus.ForwardAD    = 2'b00;
    bus.ForwardBD    = 2'b00;
  endtask

  task automatic load(input logic [31:0] ins, input logic v, input logic [7:0] c);
    bus.instructionD = ins;
    bus.validD       = v;
    bus.ctrlD        = c;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.RegWriteW = en;
    bus.WriteRegW = a;
    bus.resultW   = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    reset_n = 1'b0;
    #2;
    chk("rst_validE", 32'(bus.validE), 32'h0);
    chk("rst_ctrlE", 32'(bus.ctrlE), 32'h0);
    chk("rst_SrcAE", bus.SrcAE, 32'h0);
    chk("rst_PCsrcD", 32'(bus.PCsrcD), 32'h0);
    #10;
    reset_n = 1'b1;
    tick();

    // Same-cycle write-back bypass into SrcAE
    load(mk(5'd5, 5'd0, 16'h0000), 1'b1, 8'hA5);
    wb(1'b1, 5'd5, 32'h1234);
    chk("rsD", 32'(bus.rsD), 32'd5);
    tick();
    chk("byp_SrcAE", bus.SrcAE, 32'h1234);
    chk("byp_SrcBE", bus.SrcBE, 32'h0);
    chk("byp_validE", 32'(bus.validE), 32'h1);
    chk("byp_ctrlE", 32'(bus.ctrlE), 32'hA5);
    chk("byp_rsE", 32'(bus.rsE), 32'd5);

    // r5 really stored
    wb(1'b0, 5'd0, 32'h0);
    load(mk(5'd5, 5'd5, 16'h0000), 1'b1, 8'h01);
    tick();
    chk("r5_SrcAE", bus.SrcAE, 32'h1234);
    chk("r5_SrcBE", bus.SrcBE, 32'h1234);

    // Register 0 ignores writes, even with bypass
    load(mk(5'd0, 5'd0, 16'h0000), 1'b1, 8'h02);
    wb(1'b1, 5'd0, 32'hFFFF);
    tick();
    chk("r0_byp", bus.SrcAE, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("r0_read", bus.SrcAE, 32'h0);

    // Populate r3, r7, r1
    wb(1'b1, 5'd3, 32'd3);
    tick();
    wb(1'b1, 5'd7, 32'd7);
    tick();
    wb(1'b1, 5'd1, 32'hBEEF);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    load(mk(5'd1, 5'd3, 16'h0000), 1'b1, 8'h03);
    tick();
    chk("r1_SrcAE", bus.SrcAE, 32'hBEEF);
    chk("r3_SrcBE", bus.SrcBE, 32'd3);

    // Branch resolution with forwarding
    load(mk(5'd3, 5'd7, 16'hFFFF), 1'b1, 8'h44);
    bus.pcplus4D   = 32'h100;
    bus.BranchD    = 2'b01;
    bus.ALUresultM = 32'd7;
    bus.ForwardAD  = 2'b01;
    bus.ForwardBD  = 2'b00;
    #1;
    chk("beq_fwdM", 32'(bus.PCsrcD), 32'h1);
    chk("pcBranchD", bus.pcBranchD, 32'hFC);
    bus.ForwardAD = 2'b00;
    #1;
    chk("beq_rf_ne", 32'(bus.PCsrcD), 32'h0);
    bus.BranchD = 2'b10;
    #1;
    chk("bne_rf_ne", 32'(bus.PCsrcD), 32'h1);
    bus.validD = 1'b0;
    #1;
    chk("bne_bubble", 32'(bus.PCsrcD), 32'h0);
    bus.validD    = 1'b1;
    bus.BranchD   = 2'b01;
    bus.resultW   = 32'd3;
    bus.ForwardBD = 2'b10;
    #1;
    chk("beq_fwdW", 32'(bus.PCsrcD), 32'h1);
    bus.ForwardAD = 2'b11;
    bus.ForwardBD = 2'b11;
    #1;
    chk("beq_fwd11", 32'(bus.PCsrcD), 32'h0);
    bus.ForwardAD = 2'b01;
    bus.ForwardBD = 2'b00;
    bus.BranchD   = 2'b11;
    #1;
    chk("br_rsvd", 32'(bus.PCsrcD), 32'h0);
    bus.pcplus4D     = 32'h200;
    bus.instructionD = mk(5'd3, 5'd7, 16'h0010);
    #1;
    chk("pcBranch_fwd", bus.pcBranchD, 32'h240);
    bus.instructionD = mk(5'd3, 5'd7, 16'hFFFF);
    tick();
    chk("ld_signImmE", bus.signImmE, 32'hFFFFFFFF);
    chk("ld_rtE", 32'(bus.rtE), 32'd7);
    chk("ld_rdE", 32'(bus.rdE), 32'h1F);
    chk("ld_shamtE", 32'(bus.shamtE), 32'h1F);
    chk("ld_SrcBE", bus.SrcBE, 32'd7);

    // Bubble load zeroes control but still carries operands
    idle();
    load(mk(5'd3, 5'd0, 16'h0000), 1'b0, 8'h5A);
    tick();
    chk("bub_validE", 32'(bus.validE), 32'h0);
    chk("bub_ctrlE", 32'(bus.ctrlE), 32'h0);
    chk("bub_SrcAE", bus.SrcAE, 32'd3);

    // Flush beats stall
    load(mk(5'd7, 5'd3, 16'h1234), 1'b1, 8'hFF);
    tick();
    bus.FlushE = 1'b1;
    bus.StallE = 1'b1;
    tick();
    chk("fl_validE", 32'(bus.validE), 32'h0);
    chk("fl_ctrlE", 32'(bus.ctrlE), 32'h0);
    chk("fl_SrcAE", bus.SrcAE, 32'h0);
    chk("fl_signImmE", bus.signImmE, 32'h0);

    // Stall holds for three edges then reloads
    bus.FlushE = 1'b0;
    bus.StallE = 1'b0;
    load(mk(5'd7, 5'd3, 16'h8001), 1'b1, 8'h3C);
    tick();
    bus.StallE = 1'b1;
    load(mk(5'd3, 5'd7, 16'h0004), 1'b1, 8'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_SrcAE", bus.SrcAE, 32'd7);
      chk("st_SrcBE", bus.SrcBE, 32'd3);
      chk("st_ctrlE", 32'(bus.ctrlE), 32'h3C);
      chk("st_signImmE", bus.signImmE, 32'hFFFF8001);
      chk("st_rsE", 32'(bus.rsE), 32'd7);
    end
    bus.StallE = 1'b0;
    tick();
    chk("rel_SrcAE", bus.SrcAE, 32'd3);
    chk("rel_ctrlE", 32'(bus.ctrlE), 32'h11);
    chk("rel_signImmE", bus.signImmE, 32'h4);

    // Asynchronous reset between edges during a stall
    bus.StallE = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_validE", 32'(bus.validE), 32'h0);
    chk("ar_ctrlE", 32'(bus.ctrlE), 32'h0);
    chk("ar_SrcAE", bus.SrcAE, 32'h0);
    chk("ar_SrcBE", bus.SrcBE, 32'h0);
    chk("ar_signImmE", bus.signImmE, 32'h0);
    chk("ar_rsE", 32'(bus.rsE), 32'h0);
    tick();
    #2;
    reset_n = 1'b1;
    bus.StallE = 1'b0;
    load(mk(5'd1, 5'd7, 16'h0000), 1'b1, 8'h22);
    tick();
    chk("post_r1", bus.SrcAE, 32'h0);
    chk("post_r7", bus.SrcBE, 32'h0);
    chk("post_validE", 32'(bus.validE), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width; instruction width is fixed at 32.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count; AW = clog2(NREG).
REQ-003 The block SHALL have parameter CTRL_W, default 8, meaning width of the opaque control bundle from the control unit.
REQ-004 The block SHALL have parameter WB_BYPASS, default 1, meaning the register file forwards same-cycle writes to reads.
REQ-005 The block SHALL have one clock CLK and an asynchronous, active-low reset reset_n.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  clock, rising edge
- reset_n  in  1  async active-low reset
- instructionD  in  32  decode-stage instruction
- pcplus4D  in  XLEN  PC+4 of instructionD
- validD  in  1  instructionD is real, not a bubble
- ctrlD  in  CTRL_W  control bundle for instructionD
- BranchD  in  2  00 none, 01 BEQ, 10 BNE, 11 reserved (no branch)
- StallE  in  1  hold ID/EX contents
- FlushE  in  1  load bubble into ID/EX
- RegWriteW  in  1  write-back enable
- WriteRegW  in  AW  write-back address
- resultW  in  XLEN  write-back data
- ALUresultM  in  XLEN  memory-stage ALU result
- ForwardAD, ForwardBD  in  2 each  branch operand select: 00 regfile, 01 ALUresultM, 10 resultW, 11 regfile
- PCsrcD  out  1  branch taken
- pcBranchD  out  XLEN  branch target
- rsD, rtD  out  AW each  source fields for the hazard unit
- validE  out  1  ID/EX holds a real instruction
- ctrlE  out  CTRL_W  registered control bundle
- SrcAE, SrcBE, signImmE  out  XLEN each  registered operands and immediate
- rsE, rtE, rdE, shamtE  out  5 each  registered instruction fields

Function
REQ-007 rsD SHALL equal instr[25:21], and rtD SHALL equal instr[20:16], zero-extended or truncated to AW.
REQ-008 The register file SHALL have 2 combinational read ports and 1 write port, written on the CLK rising edge when RegWriteW=1 and WriteRegW!=0.
REQ-009 Register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-010 When WB_BYPASS=1, a read of a nonzero address equal to WriteRegW while RegWriteW=1 SHALL return resultW in the same cycle.
REQ-011 When WB_BYPASS=0, such a read SHALL return the old register value.
REQ-012 signImm SHALL be instr[15:0] sign-extended to XLEN.
REQ-013 pcBranchD SHALL equal pcplus4D + (signImm << 2), modulo 2^XLEN.
REQ-014 The branch operands SHALL be selected per ForwardAD and ForwardBD.
REQ-015 PCsrcD SHALL equal validD & (BEQ & equal | BNE & not-equal), computed combinationally from current inputs only, with no latch and no stale sensitivity.
REQ-016 The ID/EX register SHALL update on each rising edge with priority FlushE > StallE > load.
REQ-017 On flush, validE and ctrlE SHALL become 0; the other ID/EX fields SHALL be don't-care but deterministic, and SHALL be 0.
REQ-018 On stall, every ID/EX field SHALL hold its value.
REQ-019 On load, the ID/EX register SHALL capture validD, ctrlD (forced to 0 if validD=0), the read data, signImm, and the rs, rt, rd and shamt fields.
REQ-020 Decode-to-execute latency SHALL be 1 cycle.
REQ-021 Branch resolution SHALL have 0-cycle latency.
REQ-022 When a write-back and a read of the same register coincide with a load of ID/EX, SrcAE/SrcBE SHALL capture data per REQ-010 or REQ-011.

Reset
REQ-023 While reset_n=0, all ID/EX outputs and all registers SHALL be 0, asynchronously.
REQ-024 Reset asserted mid-operation SHALL override a pending stall or flush.
REQ-025 Registers SHALL leave reset on the first rising edge after reset_n rises.

Structure
REQ-026 The BranchD encodings, the ForwardXD encodings and the default widths SHALL reside in a shared package, mips_pkg.
REQ-027 The register file SHALL be the single sub-module regfile_2r1w, parametrised by XLEN, NREG and WB_BYPASS.
REQ-028 All other logic SHALL be implemented inline.

Verification
REQ-029 The bench SHALL cover write-back bypass: write r5=0x1234 with RegWriteW=1 while instr reads rs=5 with WB_BYPASS=1 -> SrcAE=0x1234 next cycle.
REQ-030 The bench SHALL cover register 0: write r0=0xFFFF, then read r0 -> 0.
REQ-031 The bench SHALL cover branch forwarding: BEQ with rd1=3, ALUresultM=7, rd2=7, ForwardAD=01 -> PCsrcD=1; pcplus4D=0x100 and imm=0xFFFF -> pcBranchD=0xFC.
REQ-032 The bench SHALL cover flush priority: FlushE=1 and StallE=1 with validD=1 -> validE=0 and ctrlE=0 next cycle.
REQ-033 The bench SHALL cover stall: a loaded instruction held 3 cycles with StallE=1 -> all E outputs unchanged, then update on the first cycle with StallE=0.
REQ-034 The bench SHALL cover reset: reset_n=0 asserted mid-stall between clock edges -> all outputs 0 immediately, and r1 reads 0 after release.
